// File: rtl/lzma_pkg.sv
// Shared definitions for the LZMA range-coder output stage.
//   - rc_state_e : FSM state encoding of the byte-out engine
//   - BYTE_FF    : the byte value whose emission is deferred until the carry is known
//   - PEND_W_DEF : default width of the deferred-0xFF run counter
package lzma_pkg;

    localparam int         PEND_W_DEF = 32;
    localparam logic [7:0] BYTE_FF    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EMIT_CACHE = 2'd1,
        ST_EMIT_FF    = 2'd2
    } rc_state_e;

endpackage

// File: rtl/lzma_rc_byte_out_if.sv
// Request/stream bundle between the range encoder core, the byte-out stage and
// the byte sink.
//   i_valid/i_ready : ShiftLow request handshake (core -> byte-out)
//   i_carry         : low[32] of the range-coder low register
//   i_byte          : low[31:24] of the range-coder low register
//   i_last          : final ShiftLow of the stream
//   o_tvalid/o_tdata/o_tlast : payload byte stream, no backpressure
//   o_count         : bytes emitted in the current stream (LZMA_OUT_BYTE_COUNT_EN only)
// modport master : range encoder side (drives requests, observes stream)
// modport slave  : byte-out stage
// Optional feature macro: LZMA_OUT_BYTE_COUNT_EN
interface lzma_rc_byte_out_if;

    logic       i_valid;
    logic       i_ready;
    logic       i_carry;
    logic [7:0] i_byte;
    logic       i_last;
    logic       o_tvalid;
    logic [7:0] o_tdata;
    logic       o_tlast;
`ifdef LZMA_OUT_BYTE_COUNT_EN
    logic [31:0] o_count;

    modport master (
        output i_valid, i_carry, i_byte, i_last,
        input  i_ready, o_tvalid, o_tdata, o_tlast, o_count
    );

    modport slave (
        input  i_valid, i_carry, i_byte, i_last,
        output i_ready, o_tvalid, o_tdata, o_tlast, o_count
    );
`else
    modport master (
        output i_valid, i_carry, i_byte, i_last,
        input  i_ready, o_tvalid, o_tdata, o_tlast
    );

    modport slave (
        input  i_valid, i_carry, i_byte, i_last,
        output i_ready, o_tvalid, o_tdata, o_tlast
    );
`endif

endinterface

// File: rtl/lzma_rc_byte_out.sv
// LZMA range-coder output stage: ShiftLow carry propagation.
// A request whose top byte is 0xFF without carry cannot be emitted yet, because a
// later carry may still ripple through it; such bytes are only counted (pend).
// Any other request flushes the held cache byte plus the pending 0xFF run, all
// adjusted by the carry, then the new byte becomes the cache.
// Ports:
//   clk  : clock, all logic on posedge
//   rstn : asynchronous active-low reset
//   bus  : lzma_rc_byte_out_if.slave (request handshake + output byte stream)
// Parameters:
//   PEND_W : width of the deferred-0xFF counter (saturates at all ones)
// Optional feature macro: LZMA_OUT_BYTE_COUNT_EN adds the o_count byte counter.
module lzma_rc_byte_out
    import lzma_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    lzma_rc_byte_out_if.slave  bus
);

    rc_state_e         state_q, state_d;
    logic [7:0]        cache_q, cache_d;
    logic [PEND_W-1:0] pend_q,  pend_d;
    logic              carry_q, carry_d;
    logic [7:0]        byte_q,  byte_d;
    logic              last_q,  last_d;
    logic              tvalid_q, tvalid_d;
    logic [7:0]        tdata_q,  tdata_d;
    logic              tlast_q,  tlast_d;

    always_comb begin
        state_d  = state_q;
        cache_d  = cache_q;
        pend_d   = pend_q;
        carry_d  = carry_q;
        byte_d   = byte_q;
        last_d   = last_q;
        tvalid_d = 1'b0;
        tdata_d  = tdata_q;
        tlast_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    if (bus.i_carry || (bus.i_byte != BYTE_FF) || bus.i_last) begin
                        // Output is registered, so the cache byte is prepared
                        // now and appears during the EMIT_CACHE cycle.
                        state_d  = ST_EMIT_CACHE;
                        carry_d  = bus.i_carry;
                        byte_d   = bus.i_byte;
                        last_d   = bus.i_last;
                        tvalid_d = 1'b1;
                        tdata_d  = cache_q + {7'd0, bus.i_carry};
                        tlast_d  = bus.i_last && (pend_q == '0);
                    end else if (pend_q != '1) begin
                        pend_d = pend_q + PEND_W'(1);
                    end
                end
            end
            ST_EMIT_CACHE, ST_EMIT_FF: begin
                // pend_q counts the 0xFF bytes still to be launched; each
                // launch decrements it, so the run length equals the
                // original pend value.
                if (pend_q == '0) begin
                    state_d = ST_IDLE;
                    cache_d = last_q ? 8'h00 : byte_q;
                    carry_d = 1'b0;
                    last_d  = 1'b0;
                end else begin
                    state_d  = ST_EMIT_FF;
                    pend_d   = pend_q - PEND_W'(1);
                    tvalid_d = 1'b1;
                    tdata_d  = BYTE_FF + {7'd0, carry_q};
                    tlast_d  = last_q && (pend_q == PEND_W'(1));
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cache_q  <= 8'h00;
            pend_q   <= '0;
            carry_q  <= 1'b0;
            byte_q   <= 8'h00;
            last_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cache_q  <= cache_d;
            pend_q   <= pend_d;
            carry_q  <= carry_d;
            byte_q   <= byte_d;
            last_q   <= last_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    assign bus.i_ready  = (state_q == ST_IDLE);
    assign bus.o_tvalid = tvalid_q;
    assign bus.o_tdata  = tdata_q;
    assign bus.o_tlast  = tlast_q;

`ifdef LZMA_OUT_BYTE_COUNT_EN
    logic [31:0] count_q, count_d;

    // Counts alongside the registered byte so the value includes the byte
    // currently on o_tdata; the stream's final byte clears it for the next one.
    always_comb begin
        if (tvalid_d) begin
            count_d = count_q + 32'd1;
        end else if (tlast_q) begin
            count_d = 32'd0;
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.o_count = count_q;
`endif

endmodule

// File: tb/tb_lzma_rc_byte_out.sv
// Self-checking bench for lzma_rc_byte_out: hand-computed vector table, reset and
// abort sequences, and randomized requests against a ShiftLow reference model.
// Optional feature macro: LZMA_OUT_BYTE_COUNT_EN (enables o_count checks).
module tb_lzma_rc_byte_out;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lzma_rc_byte_out_if bus();

    lzma_rc_byte_out #(.PEND_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- output monitor ----------------
    logic [7:0] got_d[$];
    bit         got_l[$];
    int         got_t[$];

    always @(negedge clk) begin
        if (rstn && bus.o_tvalid) begin
            got_d.push_back(bus.o_tdata);
            got_l.push_back(bus.o_tlast);
            got_t.push_back(cyc);
        end
    end

`ifdef LZMA_OUT_BYTE_COUNT_EN
    int exp_cnt   = 0;
    bit prev_last = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            exp_cnt   = 0;
            prev_last = 1'b0;
        end else begin
            if (bus.o_tvalid) begin
                exp_cnt++;
                chk("o_count", bus.o_count, exp_cnt);
            end else if (prev_last) begin
                exp_cnt = 0;
                chk("o_count_clr", bus.o_count, 32'd0);
            end
            prev_last = bus.o_tvalid && bus.o_tlast;
        end
    end
`endif

    // ---------------- reference model ----------------
    // LZMA ShiftLow: a byte is final only once a non-0xFF (or carrying) byte
    // follows it; the cache and the run of 0xFFs are then flushed with carry.
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    bit [7:0]   m_cache = 8'h00;
    int         m_pend  = 0;

    function automatic void model(input bit c, input bit [7:0] b, input bit l);
        bit [7:0] v;
        if (c || b != 8'hFF || l) begin
            v = m_cache + {7'd0, c};
            exp_d.push_back(v);
            exp_l.push_back(l && m_pend == 0);
            for (int i = 0; i < m_pend; i++) begin
                v = c ? 8'h00 : 8'hFF;
                exp_d.push_back(v);
                exp_l.push_back(l && i == m_pend - 1);
            end
            m_cache = l ? 8'h00 : b;
            m_pend  = 0;
        end else begin
            m_pend++;
        end
    endfunction

    function automatic void clear_all();
        got_d.delete(); got_l.delete(); got_t.delete();
        exp_d.delete(); exp_l.delete();
        m_cache = 8'h00;
        m_pend  = 0;
    endfunction

    // ---------------- driver ----------------
    task automatic send(input bit c, input bit [7:0] b, input bit l, output int busy);
        int guard = 0;
        @(negedge clk);
        while (!bus.i_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) chk("ready_timeout", 32'd0, 32'd1);
        bus.i_valid = 1'b1;
        bus.i_carry = c;
        bus.i_byte  = b;
        bus.i_last  = l;
        @(negedge clk);
        bus.i_valid = 1'b0;
        busy = 0;
        while (!bus.i_ready && busy < 1000) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic compare(input string nm, input int busy);
        int n;
        chk({nm, "_len"}, got_d.size(), exp_d.size());
        chk({nm, "_busy"}, busy, exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_data"}, got_d[i], exp_d[i]);
            chk({nm, "_last"}, got_l[i], exp_l[i]);
        end
        if (got_t.size() > 1)
            chk({nm, "_gapfree"}, got_t[got_t.size()-1] - got_t[0], got_t.size() - 1);
        got_d.delete(); got_l.delete(); got_t.delete();
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        clear_all();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit       c;
        bit [7:0] b;
        bit       l;
        int       n;
        bit [7:0] e0, e1, e2;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int busy;
        bit [7:0] ev[3];
        bit c, l;
        bit [7:0] b;

        bus.i_valid = 1'b0;
        bus.i_carry = 1'b0;
        bus.i_byte  = 8'h00;
        bus.i_last  = 1'b0;

        tbl[0]  = '{1'b0, 8'h12, 1'b0, 1, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 8'h34, 1'b1, 1, 8'h12, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 8'hAA, 1'b0, 1, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        tbl[5]  = '{1'b0, 8'h10, 1'b0, 3, 8'hAA, 8'hFF, 8'hFF};
        tbl[6]  = '{1'b0, 8'hAA, 1'b0, 1, 8'h10, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        tbl[8]  = '{1'b0, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        tbl[9]  = '{1'b1, 8'h05, 1'b0, 3, 8'hAB, 8'h00, 8'h00};
        tbl[10] = '{1'b0, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 8'hFF, 1'b1, 2, 8'h05, 8'hFF, 8'h00};
        tbl[12] = '{1'b1, 8'h20, 1'b0, 1, 8'h01, 8'h00, 8'h00};
        tbl[13] = '{1'b0, 8'h30, 1'b1, 1, 8'h20, 8'h00, 8'h00};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tvalid", bus.o_tvalid, 1'b0);
        chk("rst_tdata",  bus.o_tdata,  8'h00);
        chk("rst_tlast",  bus.o_tlast,  1'b0);
        chk("rst_ready",  bus.i_ready,  1'b1);
`ifdef LZMA_OUT_BYTE_COUNT_EN
        chk("rst_count",  bus.o_count,  32'd0);
`endif
        rstn = 1'b1;
        clear_all();

        // table-driven sequence (busy check also covers ready-low duration)
        for (int k = 0; k < 14; k++) begin
            ev[0] = tbl[k].e0; ev[1] = tbl[k].e1; ev[2] = tbl[k].e2;
            for (int j = 0; j < tbl[k].n; j++) begin
                exp_d.push_back(ev[j]);
                exp_l.push_back(tbl[k].l && j == tbl[k].n - 1);
            end
            send(tbl[k].c, tbl[k].b, tbl[k].l, busy);
            compare($sformatf("tbl%0d", k), busy);
        end

        // reset during an EMIT_FF run of 5
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(1'b0, 8'hFF, 1'b0, busy);
            chk("abort_defer", busy, 0);
        end
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_carry = 1'b0;
        bus.i_byte  = 8'h40;
        bus.i_last  = 1'b0;
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("abort_cache", bus.o_tdata, 8'h00);
        @(negedge clk);
        chk("abort_ff1", bus.o_tdata, 8'hFF);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort_tvalid", bus.o_tvalid, 1'b0);
        chk("abort_tdata",  bus.o_tdata,  8'h00);
        chk("abort_ready",  bus.i_ready,  1'b1);
        @(negedge clk);
        rstn = 1'b1;
        clear_all();
        model(1'b0, 8'h77, 1'b1);
        send(1'b0, 8'h77, 1'b1, busy);
        compare("after_abort", busy);

        // 7-byte stream (o_count 1..7 then 0 when counting is built in)
        do_reset();
        ev[0] = 8'h11;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: b = 8'h11;
                1: b = 8'h22;
                2: b = 8'h33;
                3: b = 8'h44;
                6: b = 8'h55;
                default: b = 8'hFF;
            endcase
            l = (k == 6);
            model(1'b0, b, l);
            send(1'b0, b, l, busy);
            compare($sformatf("seven%0d", k), busy);
        end
        repeat (2) @(negedge clk);

        // randomized requests against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            b = ($urandom_range(0, 9) < 4) ? 8'hFF : 8'($urandom);
            c = ($urandom_range(0, 7) == 0);
            l = ($urandom_range(0, 24) == 0);
            model(c, b, l);
            send(c, b, l, busy);
            compare("rand", busy);
        end
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
